// File: rtl/pdu_input_pkg.sv
// pdu_input_pkg
//   Shared constants, FSM/event enums and a helper for the PDU input stage.
//   NUM_SW      : number of hex-digit switches
//   MAX_DIGITS  : digits held in the 32-bit shift register
//   DEF_*       : default debouncer timing
package pdu_input_pkg;

    localparam int NUM_SW          = 16;
    localparam int MAX_DIGITS      = 8;
    localparam int DEF_DEB_CYCLES  = 1_000_000;
    localparam int DEF_SAMPLES     = 3;
    localparam int DEF_SYNC_STAGES = 2;
    // Debounced vector layout: {btn, del, sw[15:0]}
    localparam int DEB_W           = NUM_SW + 2;

    typedef enum logic [1:0] {INIT, RUN, CLEAR} state_e;
    typedef enum logic [1:0] {EV_NONE, EV_DIGIT, EV_DEL, EV_COMMIT} event_e;

    // Index of the lowest set bit; 0 when none set (caller qualifies with |v).
    function automatic logic [3:0] lowest_set(input logic [NUM_SW-1:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/pdu_input_ctrl_debouncer.sv
// input_debouncer
//   Synchroniser + tick-gated sample history + debounced level register for
//   W independent inputs.
//   clk, rst     : clock, synchronous active-high reset
//   tick         : sample strobe from the shared prescaler
//   init_load    : when high, the level follows each new sample directly
//                  instead of waiting for a full matching history
//   raw[W-1:0]   : asynchronous raw inputs
//   level[W-1:0] : debounced levels
module input_debouncer #(
    parameter int W           = 18,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLES     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         init_load,
    input  logic [W-1:0] raw,
    output logic [W-1:0] level
);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
    // hist_q[0] is the newest sample
    logic [SAMPLES-1:0][W-1:0]     hist_q, hist_d;
    logic [W-1:0]                  level_q, level_d;
    logic [W-1:0]                  smp;

    assign smp   = sync_q[SYNC_STAGES-1];
    assign level = level_q;

    always_comb begin
        logic all1;
        logic all0;
        all1 = 1'b0;
        all0 = 1'b0;

        sync_d    = sync_q;
        sync_d[0] = raw;
        for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];

        hist_d = hist_q;
        if (tick) begin
            hist_d[0] = smp;
            for (int s = 1; s < SAMPLES; s++) hist_d[s] = hist_q[s-1];
        end

        level_d = level_q;
        if (init_load) begin
            // Track the input without filtering so the level is already
            // correct when event processing starts.
            if (tick) level_d = smp;
        end else begin
            for (int b = 0; b < W; b++) begin
                all1 = 1'b1;
                all0 = 1'b1;
                for (int s = 0; s < SAMPLES; s++) begin
                    all1 = all1 & hist_q[s][b];
                    all0 = all0 & ~hist_q[s][b];
                end
                if (all1)      level_d[b] = 1'b1;
                else if (all0) level_d[b] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            hist_q  <= '0;
            level_q <= '0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/pdu_input_ctrl.sv
// pdu_input_ctrl
//   Front-end input stage of the PDU data bus: debounces switches/buttons and
//   assembles hex digits into a 32-bit shift register.
//   clk, rst        : clock, synchronous active-high reset
//   sw_raw[15:0]    : raw switches, switch i enters hex digit i on any edge
//   del_raw         : raw delete button (removes newest digit)
//   btn_raw         : raw commit button
//   shift_reg_data  : assembled value, newest digit in [3:0]
//   digit_cnt       : number of valid digits, 0..8
//   btn             : one-cycle commit pulse; shift_reg_data clears next cycle
module pdu_input_ctrl
    import pdu_input_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int SAMPLES     = DEF_SAMPLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw_raw,
    input  logic        del_raw,
    input  logic        btn_raw,
    output logic [31:0] shift_reg_data,
    output logic [3:0]  digit_cnt,
    output logic        btn
);

    localparam int PW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int IW = $clog2(SAMPLES + 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    logic [DEB_W-1:0] lvl;
    logic [DEB_W-1:0] prev_q, prev_d;
    logic [NUM_SW-1:0] sw_edge;
    logic             del_rise, btn_rise;
    logic [3:0]       dig;
    event_e           ev;

    state_e           state_q, state_d;
    logic [IW-1:0]    init_cnt_q, init_cnt_d;
    logic [31:0]      shift_q, shift_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             btn_q, btn_d;

    // Free-running prescaler shared by all debouncer lanes.
    assign tick    = (presc_q == PW'(DEB_CYCLES - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    input_debouncer #(
        .W           (DEB_W),
        .SYNC_STAGES (SYNC_STAGES),
        .SAMPLES     (SAMPLES)
    ) u_deb (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .init_load (state_q == INIT),
        .raw       ({btn_raw, del_raw, sw_raw}),
        .level     (lvl)
    );

    // Event detection against the previous-cycle debounced levels.
    always_comb begin
        prev_d   = lvl;
        sw_edge  = lvl[NUM_SW-1:0] ^ prev_q[NUM_SW-1:0];
        del_rise = lvl[NUM_SW]   & ~prev_q[NUM_SW];
        btn_rise = lvl[NUM_SW+1] & ~prev_q[NUM_SW+1];
        dig      = lowest_set(sw_edge);
        if (btn_rise)      ev = EV_COMMIT;
        else if (del_rise) ev = EV_DEL;
        else if (|sw_edge) ev = EV_DIGIT;
        else               ev = EV_NONE;
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        btn_d      = 1'b0;
        case (state_q)
            INIT: begin
                // Leave one cycle after the last init tick so prev_q has
                // caught up with the freshly loaded levels.
                if (init_cnt_q == IW'(SAMPLES)) state_d = RUN;
                else if (tick)                  init_cnt_d = init_cnt_q + 1'b1;
            end
            RUN: begin
                case (ev)
                    EV_COMMIT: begin
                        btn_d   = 1'b1;
                        state_d = CLEAR;
                    end
                    EV_DEL: begin
                        if (cnt_q != 4'd0) begin
                            shift_d = {4'h0, shift_q[31:4]};
                            cnt_d   = cnt_q - 1'b1;
                        end
                    end
                    EV_DIGIT: begin
                        shift_d = {shift_q[27:0], dig};
                        if (cnt_q != 4'(MAX_DIGITS)) cnt_d = cnt_q + 1'b1;
                    end
                    default: ;
                endcase
            end
            CLEAR: begin
                shift_d = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            prev_q     <= '0;
            state_q    <= INIT;
            init_cnt_q <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            btn_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            prev_q     <= prev_d;
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            btn_q      <= btn_d;
        end
    end

    assign shift_reg_data = shift_q;
    assign digit_cnt      = cnt_q;
    assign btn            = btn_q;

endmodule

// File: tb/tb_pdu_input_ctrl.sv
module tb_pdu_input_ctrl;
    import pdu_input_pkg::*;

    localparam int DEB  = 4;
    localparam int SMP  = 3;
    localparam int HOLD = 6 * DEB;   // comfortably beyond worst-case latency

    localparam int OP_SW  = 0;
    localparam int OP_DEL = 1;
    localparam int OP_BTN = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw_raw = 16'h0;
    logic        del_raw = 1'b0;
    logic        btn_raw = 1'b0;
    logic [31:0] shift_reg_data;
    logic [3:0]  digit_cnt;
    logic        btn;

    pdu_input_ctrl #(.DEB_CYCLES(DEB), .SAMPLES(SMP), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .sw_raw         (sw_raw),
        .del_raw        (del_raw),
        .btn_raw        (btn_raw),
        .shift_reg_data (shift_reg_data),
        .digit_cnt      (digit_cnt),
        .btn            (btn)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference model: list of entered digits, oldest first.
    int dq[$];

    function automatic logic [31:0] m_val();
        logic [31:0] v;
        v = 32'h0;
        foreach (dq[k]) v = (v << 4) | 32'(dq[k]);
        return v;
    endfunction

    task automatic m_digit(input int i);
        dq.push_back(i);
        if (dq.size() > MAX_DIGITS) void'(dq.pop_front());
    endtask

    task automatic m_del();
        if (dq.size() > 0) void'(dq.pop_back());
    endtask

    // Commit-pulse monitor: counts pulses, captures the value shown during the
    // pulse, and checks the cycle after a pulse is cleared and pulse-free.
    int          npulse = 0;
    logic [31:0] pulse_val = 32'h0;
    bit          pend = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("post_btn_val", shift_reg_data, 32'h0);
                check("post_btn_cnt", 32'(digit_cnt), 32'h0);
                check("post_btn_low", 32'(btn), 32'h0);
            end
            pend = btn;
            if (btn) begin
                npulse++;
                pulse_val = shift_reg_data;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_sw(input int i);
        sw_raw[i] = ~sw_raw[i];
        m_digit(i);
        cyc(HOLD);
    endtask

    task automatic do_del();
        del_raw = 1'b1;
        cyc(HOLD);
        del_raw = 1'b0;
        cyc(HOLD);
        m_del();
    endtask

    task automatic do_btn();
        int          p0;
        logic [31:0] e;
        p0 = npulse;
        e  = m_val();
        btn_raw = 1'b1;
        cyc(HOLD);
        btn_raw = 1'b0;
        cyc(HOLD);
        check("btn_pulses", 32'(npulse - p0), 32'd1);
        check("btn_pulse_val", pulse_val, e);
        dq.delete();
    endtask

    task automatic check_model(input string tag);
        check({tag, "_val"}, shift_reg_data, m_val());
        check({tag, "_cnt"}, 32'(digit_cnt), 32'(dq.size()));
    endtask

    typedef struct {
        int          op;
        int          idx;
        logic [31:0] val;
        int          cnt;
        logic [31:0] pv;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int op, input int idx, input logic [31:0] val,
                       input int cnt, input logic [31:0] pv);
        vec_t v;
        v.op = op; v.idx = idx; v.val = val; v.cnt = cnt; v.pv = pv;
        tbl.push_back(v);
    endtask

    initial begin
        int p0;

        add(OP_SW,  2,  32'h0000_0002, 1, 0);
        add(OP_DEL, 0,  32'h0000_0000, 0, 0);
        add(OP_SW,  3,  32'h0000_0003, 1, 0);
        add(OP_SW,  10, 32'h0000_003A, 2, 0);
        add(OP_DEL, 0,  32'h0000_0003, 1, 0);
        add(OP_DEL, 0,  32'h0000_0000, 0, 0);
        add(OP_DEL, 0,  32'h0000_0000, 0, 0);
        add(OP_SW,  1,  32'h0000_0001, 1, 0);
        add(OP_SW,  2,  32'h0000_0012, 2, 0);
        add(OP_SW,  3,  32'h0000_0123, 3, 0);
        add(OP_SW,  4,  32'h0000_1234, 4, 0);
        add(OP_SW,  5,  32'h0001_2345, 5, 0);
        add(OP_SW,  6,  32'h0012_3456, 6, 0);
        add(OP_SW,  7,  32'h0123_4567, 7, 0);
        add(OP_SW,  8,  32'h1234_5678, 8, 0);
        add(OP_SW,  9,  32'h2345_6789, 8, 0);
        add(OP_BTN, 0,  32'h0000_0000, 0, 32'h2345_6789);

        // Reset with a switch already on: must not become a digit.
        sw_raw = 16'h0004;
        rst = 1'b1;
        cyc(3);
        check("rst_val", shift_reg_data, 32'h0);
        check("rst_cnt", 32'(digit_cnt), 32'h0);
        check("rst_btn", 32'(btn), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(INIT));
        rst = 1'b0;
        cyc(20 * DEB);
        check("init_sw_val", shift_reg_data, 32'h0);
        check("init_sw_cnt", 32'(digit_cnt), 32'h0);
        check("init_sw_pulses", 32'(npulse), 32'h0);

        for (int k = 0; k < tbl.size(); k++) begin
            case (tbl[k].op)
                OP_SW:   do_sw(tbl[k].idx);
                OP_DEL:  do_del();
                default: do_btn();
            endcase
            check($sformatf("tbl%0d_val", k), shift_reg_data, tbl[k].val);
            check($sformatf("tbl%0d_cnt", k), 32'(digit_cnt), 32'(tbl[k].cnt));
            if (tbl[k].op == OP_BTN)
                check($sformatf("tbl%0d_pulse", k), pulse_val, tbl[k].pv);
        end

        // Commit button bouncing every cycle, then held: exactly one pulse.
        do_sw(11);
        do_sw(12);
        check_model("pre_bounce");
        p0 = npulse;
        for (int c = 0; c < 10; c++) begin
            btn_raw = ~btn_raw;
            cyc(1);
        end
        btn_raw = 1'b1;
        cyc(HOLD);
        check("bounce_pulses", 32'(npulse - p0), 32'd1);
        check("bounce_pulse_val", pulse_val, 32'h0000_00BC);
        dq.delete();
        btn_raw = 1'b0;
        cyc(HOLD);
        check("bounce_release_pulses", 32'(npulse - p0), 32'd1);
        check_model("bounce");

        // Commit and switch edge debounced in the same cycle: digit dropped.
        do_sw(13);
        p0 = npulse;
        btn_raw = 1'b1;
        sw_raw[5] = ~sw_raw[5];
        cyc(HOLD);
        btn_raw = 1'b0;
        cyc(HOLD);
        check("same_cyc_pulses", 32'(npulse - p0), 32'd1);
        check("same_cyc_pulse_val", pulse_val, 32'h0000_000D);
        check("same_cyc_val", shift_reg_data, 32'h0);
        check("same_cyc_cnt", 32'(digit_cnt), 32'h0);
        dq.delete();

        // Reset while a switch change is half-way through the history.
        do_sw(14);
        check_model("pre_rst");
        sw_raw[7] = ~sw_raw[7];
        cyc(6);
        p0 = npulse;
        rst = 1'b1;
        cyc(1);
        check("midrst_val", shift_reg_data, 32'h0);
        check("midrst_cnt", 32'(digit_cnt), 32'h0);
        check("midrst_btn", 32'(btn), 32'h0);
        check("midrst_state", 32'(dut.state_q), 32'(INIT));
        rst = 1'b0;
        dq.delete();
        cyc(10 * DEB);
        check("midrst_after_val", shift_reg_data, 32'h0);
        check("midrst_after_cnt", 32'(digit_cnt), 32'h0);
        check("midrst_after_pulses", 32'(npulse - p0), 32'd0);

        // Randomised operations against the digit-list model.
        for (int n = 0; n < 30; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70)      do_sw(int'($urandom_range(0, 15)));
            else if (r < 85) do_del();
            else             do_btn();
            check_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pdu_input_ctrl.md
# pdu_input_ctrl

Front-end input stage for the PDU data bus. It synchronises and debounces the raw board switches and buttons, and assembles hex digits into a 32-bit shift register. It produces the `shift_reg_data` word and the one-cycle `btn` commit pulse consumed by the MMIO memory map, which latches `sw_input` and sets `btn_status` on that pulse.

## Interface
Parameters:
- `DEB_CYCLES`, default 1_000_000: sample-tick period in clk cycles (10 ms @ 100 MHz).
- `SAMPLES`, default 3: consecutive equal tick-samples required to accept a new level.
- `SYNC_STAGES`, default 2: synchroniser flops per raw input.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `sw_raw` in 16: raw switches; switch i carries hex digit i.
- `del_raw` in 1: raw delete (backspace) button.
- `btn_raw` in 1: raw commit button.
- `shift_reg_data` out 32: assembled value, newest digit in [3:0].
- `digit_cnt` out 4: valid digits, 0..8.
- `btn` out 1: one-cycle commit pulse.

## Operation
- **Synchroniser:** each raw input passes through `SYNC_STAGES` flops.
- **Prescaler:** counts 0..`DEB_CYCLES`-1. `tick` asserts for one cycle when the count wraps.
- **Debouncer:** on each tick, every synchronised input shifts into a `SAMPLES`-deep history. The debounced level updates only when all history bits are equal and differ from the current level.
- **Events** are evaluated each cycle from debounced levels versus their previous-cycle copies:
  - commit: `btn_deb` rising edge.
  - delete: `del_deb` rising edge.
  - digit: any edge (either direction) on `sw_deb[i]`. If several switches change in the same cycle, the lowest i wins and the rest are discarded.
- **Priority per cycle:** commit > delete > digit. Lower-priority events in that cycle are dropped.
- **Digit:**
  - `shift_reg_data <= {shift_reg_data[27:0], i[3:0]}`.
  - `digit_cnt` increments and saturates at 8. Beyond 8 digits the oldest digit falls off the top.
- **Delete:**
  - If `digit_cnt` > 0: `shift_reg_data <= {4'h0, shift_reg_data[31:4]}` and `digit_cnt` decrements.
  - If `digit_cnt` = 0: no-op.
- **Commit:**
  - `btn` = 1 for exactly one cycle. `shift_reg_data` is unchanged during that cycle.
  - The next cycle clears `shift_reg_data` and `digit_cnt` to 0.
- **FSM:**
  - INIT: entered on reset. Debouncers run, debounced levels load directly from the history, and all events are suppressed. After `SAMPLES` ticks, go to RUN.
  - RUN: normal event processing.
  - CLEAR: the single cycle following a commit. Performs the clear, ignores new events, then returns to RUN.
  - INIT ensures switches already on at reset never create a spurious digit.

## Timing
- **Reset values:** `shift_reg_data`=0, `digit_cnt`=0, `btn`=0, prescaler=0, histories=0, state=INIT.
- **Reset mid-operation:** all outputs are 0 on the cycle after `rst` is sampled high, and the FSM returns to INIT.
- **Latency:** from a stable raw change to the debounced edge is at most `SYNC_STAGES` + `SAMPLES`·`DEB_CYCLES` + 1 cycles. The register update or `btn` pulse follows 1 cycle after the edge.
- **Bounce filtering:** any bounce shorter than `SAMPLES`−1 tick periods produces no event. One press yields exactly one `btn` pulse.
- **Output stability:** `shift_reg_data` is registered and changes only on digit, delete or clear cycles.
- **Prescaler:** free-running, with no dependence on event activity.

## Structure
- Package `pdu_input_pkg`:
  - `NUM_SW`=16, `MAX_DIGITS`=8.
  - Default `DEB_CYCLES`/`SAMPLES`.
  - FSM state enum {INIT, RUN, CLEAR}.
  - Event enum {EV_NONE, EV_DIGIT, EV_DEL, EV_COMMIT}.
- Sub-module `input_debouncer`: parameterised width W. Contains synchroniser, tick-gated sample history and level register, plus an `init_load` input used during INIT. It is instantiated once with W=18 (`sw`, `del`, `btn`). The prescaler sits in the top level and is shared via `tick`.

## Test plan
All scenarios use `DEB_CYCLES`=4, `SAMPLES`=3.
1. Reset with `sw_raw`=16'h0004 held, run 20 ticks -> no digit event; `shift_reg_data`=0, `digit_cnt`=0.
2. From reset, toggle `sw[3]` then `sw[10]`, each held 5 ticks -> `shift_reg_data`=32'h0000_003A, `digit_cnt`=2.
3. Enter digits 1..9 in sequence -> `shift_reg_data`=32'h2345_6789, `digit_cnt`=8 (saturated).
4. With 32'h3A, press `del` -> 32'h3, `digit_cnt`=1. Press twice more -> 0 then no-op; `digit_cnt` stays 0 with no underflow.
5. `btn_raw` bounces every cycle for 10 cycles, then holds high -> exactly one 1-cycle `btn` pulse with `shift_reg_data`=prior value, then 0 and `digit_cnt`=0 on the next cycle.
6. Debounced `btn` rise and `sw[5]` edge in the same cycle -> commit only, digit dropped. Assert `rst` during a half-accumulated history -> outputs 0 next cycle, state INIT, and no event fires from the stale history.
